// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: state encoding,
// the bundle of stage-register controls, and the bubble field values.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DWAIT = 2'd2
  } ctrl_state_e;

  // PC hold plus the hold/flush controls of the inter-stage registers.
  // MEM/WB has no hold; it can only be bubbled.
  typedef struct packed {
    logic pc_hold;
    logic ifid_hold;
    logic idex_hold;
    logic exmem_hold;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } hz_ctrl_t;

  // Fields a stage register loads when it is flushed.
  typedef struct packed {
    logic insthit;
    logic write_enable;
    logic mem_write;
    logic mem_read;
  } bubble_t;

  localparam bubble_t BUBBLE = '{insthit: 1'b0, write_enable: 1'b0,
                                 mem_write: 1'b0, mem_read: 1'b0};

  localparam hz_ctrl_t CTRL_NONE = '0;

  // A register that is held must keep its contents, so hold beats flush.
  function automatic hz_ctrl_t hold_wins(input hz_ctrl_t c);
    hz_ctrl_t r;
    r = c;
    r.ifid_flush  = c.ifid_flush  & ~c.ifid_hold;
    r.idex_flush  = c.idex_flush  & ~c.idex_hold;
    r.exmem_flush = c.exmem_flush & ~c.exmem_hold;
    return r;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from the pipeline and stage-register controls back to it.
// master = the hazard controller, slave = the pipeline datapath.
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] ex_rd;
  logic       ex_memRead;
  logic       ex_redirect;
  logic       imem_busywait;
  logic       dmem_busywait;

  logic       pc_hold;
  logic       ifid_hold;
  logic       idex_hold;
  logic       exmem_hold;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_flush;
  logic       memwb_flush;

  modport master (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memRead,
           ex_redirect, imem_busywait, dmem_busywait,
    output pc_hold, ifid_hold, idex_hold, exmem_hold,
           ifid_flush, idex_flush, exmem_flush, memwb_flush
  );

  modport slave (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memRead,
           ex_redirect, imem_busywait, dmem_busywait,
    input  pc_hold, ifid_hold, idex_hold, exmem_hold,
           ifid_flush, idex_flush, exmem_flush, memwb_flush
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear takes priority over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;

  // Next count: clear, else increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (inc && (count_q != '1))
      count_d = count_q + W'(1);
  end

  // Count register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline. Controls are Mealy
// outputs of the current state and hazard inputs; state, the INIT
// sequencer, the sticky timeout and the counters are registered.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES  = 4,
  parameter int DMEM_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic               clock,
  input  logic               reset,
  pipe_hazard_ctrl_if.master hz,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic               dmem_timeout,
  output logic [1:0]         ctrl_state
);
  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int TO_W   = $clog2(DMEM_TIMEOUT + 1);

  ctrl_state_e       state_q, state_d, cur_state;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic              timeout_q, timeout_d;
  logic [TO_W-1:0]   busy_cnt;
  hz_ctrl_t          ctrl_raw, ctrl;
  logic              in_init, load_use, timeout_hit;

  // Reset forces the INIT view immediately, before the reset edge lands.
  assign cur_state = reset ? ST_INIT : state_q;
  assign in_init   = (cur_state == ST_INIT);

  assign load_use = hz.ex_memRead && (hz.ex_rd != 5'd0) &&
                    ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

  // Priority decode of the stage controls; DWAIT decodes like RUN.
  always_comb begin
    ctrl_raw = CTRL_NONE;
    if (in_init) begin
      ctrl_raw.pc_hold     = 1'b1;
      ctrl_raw.ifid_flush  = 1'b1;
      ctrl_raw.idex_flush  = 1'b1;
      ctrl_raw.exmem_flush = 1'b1;
      ctrl_raw.memwb_flush = 1'b1;
    end else if (hz.dmem_busywait) begin
      ctrl_raw.pc_hold     = 1'b1;
      ctrl_raw.ifid_hold   = 1'b1;
      ctrl_raw.idex_hold   = 1'b1;
      ctrl_raw.exmem_hold  = 1'b1;
      ctrl_raw.memwb_flush = 1'b1;
    end else if (hz.ex_redirect) begin
      ctrl_raw.ifid_flush  = 1'b1;
      ctrl_raw.idex_flush  = 1'b1;
    end else if (load_use) begin
      ctrl_raw.pc_hold     = 1'b1;
      ctrl_raw.ifid_hold   = 1'b1;
      ctrl_raw.idex_flush  = 1'b1;
    end else if (hz.imem_busywait) begin
      ctrl_raw.pc_hold     = 1'b1;
      ctrl_raw.ifid_flush  = 1'b1;
    end
  end

  assign ctrl = hold_wins(ctrl_raw);

  assign hz.pc_hold     = ctrl.pc_hold;
  assign hz.ifid_hold   = ctrl.ifid_hold;
  assign hz.idex_hold   = ctrl.idex_hold;
  assign hz.exmem_hold  = ctrl.exmem_hold;
  assign hz.ifid_flush  = ctrl.ifid_flush;
  assign hz.idex_flush  = ctrl.idex_flush;
  assign hz.exmem_flush = ctrl.exmem_flush;
  assign hz.memwb_flush = ctrl.memwb_flush;

  // Consecutive D-memory busy cycles; restarts whenever busywait drops.
  sat_counter #(.W(TO_W)) u_busy_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (!in_init && hz.dmem_busywait),
    .clear (in_init || !hz.dmem_busywait),
    .count (busy_cnt)
  );

  // The DMEM_TIMEOUT-th busy cycle raises the flag in that same cycle.
  assign timeout_hit  = !in_init && hz.dmem_busywait &&
                        (busy_cnt == TO_W'(DMEM_TIMEOUT - 1));
  assign dmem_timeout = !reset && (timeout_q || timeout_hit);

  // Next state: INIT walks one cycle per stage register, then RUN/DWAIT
  // simply track dmem_busywait.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    timeout_d  = timeout_q || timeout_hit;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_W'(INIT_CYCLES - 1))
          state_d = ST_RUN;
        else
          init_cnt_d = init_cnt_q + INIT_W'(1);
      end
      default: state_d = hz.dmem_busywait ? ST_DWAIT : ST_RUN;
    endcase
  end

  // State registers; reset re-enters INIT regardless of inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (!in_init && ctrl.pc_hold),
    .clear (1'b0),
    .count (stall_cnt)
  );

  // A redirect is accepted only when a D-memory stall does not override it.
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (!in_init && !hz.dmem_busywait && hz.ex_redirect),
    .clear (1'b0),
    .count (flush_cnt)
  );

  assign ctrl_state = cur_state;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each driven cycle pushes the
// expected controls/state/counters, the negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
  localparam int CW  = 4;
  localparam int TMO = 64;
  localparam int SAT = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic          dmem_timeout;
  logic [1:0]    ctrl_state;

  pipe_hazard_ctrl_if hz_if();

  pipe_hazard_ctrl #(.INIT_CYCLES(4), .DMEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .hz           (hz_if),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .dmem_timeout (dmem_timeout),
    .ctrl_state   (ctrl_state)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [7:0] ctrl;   // {pc,ifid_h,idex_h,exmem_h,ifid_f,idex_f,exmem_f,memwb_f}
    logic [1:0] st;
    int         stall;
    int         flush;
    logic       to;
    bit         cnt_ok;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model state
  int m_state = 0, m_icnt = 0, m_stall = 0, m_flush = 0, m_busy = 0;
  bit m_to = 1'b0, m_known = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit [4:0] rs1, input bit [4:0] rs2,
                       input bit u1, input bit u2, input bit [4:0] rd, input bit mr,
                       input bit redir, input bit imiss, input bit dbusy);
    exp_t       e;
    logic [7:0] c;
    bit         lu, init;
    @(posedge clock);
    #1;
    reset                = rst;
    hz_if.id_rs1         = rs1;
    hz_if.id_rs2         = rs2;
    hz_if.id_use_rs1     = u1;
    hz_if.id_use_rs2     = u2;
    hz_if.ex_rd          = rd;
    hz_if.ex_memRead     = mr;
    hz_if.ex_redirect    = redir;
    hz_if.imem_busywait  = imiss;
    hz_if.dmem_busywait  = dbusy;
    cyc++;
    lu   = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    init = rst || (m_state == 0);
    if (init)       c = 8'b1000_1111;
    else if (dbusy) c = 8'b1111_0001;
    else if (redir) c = 8'b0000_1100;
    else if (lu)    c = 8'b1100_0100;
    else if (imiss) c = 8'b1000_1000;
    else            c = 8'b0000_0000;
    e.cyc    = cyc;
    e.ctrl   = c;
    e.st     = init ? 2'd0 : 2'(m_state);
    e.stall  = m_stall;
    e.flush  = m_flush;
    e.to     = !rst && (m_to || (!init && dbusy && m_busy == TMO - 1));
    e.cnt_ok = m_known;
    sb.push_back(e);
    if (rst) begin
      m_state = 0; m_icnt = 0; m_stall = 0; m_flush = 0;
      m_to = 1'b0; m_busy = 0; m_known = 1'b1;
    end else if (m_state == 0) begin
      m_busy = 0;
      if (m_icnt == 3) m_state = 1;
      else             m_icnt++;
    end else begin
      if (c[7] && m_stall < SAT) m_stall++;
      if (!dbusy && redir && m_flush < SAT) m_flush++;
      if (e.to) m_to = 1'b1;
      m_busy  = dbusy ? m_busy + 1 : 0;
      m_state = dbusy ? 2 : 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rst_seq(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare every expected record away from the active edge.
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk($sformatf("c%0d ctrl", mon_e.cyc),
          {24'd0, hz_if.pc_hold, hz_if.ifid_hold, hz_if.idex_hold, hz_if.exmem_hold,
           hz_if.ifid_flush, hz_if.idex_flush, hz_if.exmem_flush, hz_if.memwb_flush},
          {24'd0, mon_e.ctrl});
      chk($sformatf("c%0d state", mon_e.cyc), {30'd0, ctrl_state}, {30'd0, mon_e.st});
      chk($sformatf("c%0d timeout", mon_e.cyc), {31'd0, dmem_timeout}, {31'd0, mon_e.to});
      if (mon_e.cnt_ok) begin
        chk($sformatf("c%0d stall_cnt", mon_e.cyc), {28'd0, stall_cnt}, mon_e.stall);
        chk($sformatf("c%0d flush_cnt", mon_e.cyc), {28'd0, flush_cnt}, mon_e.flush);
      end
    end
  end

  initial begin
    // Reset then the INIT flush sequence and a little RUN
    rst_seq(2);
    idle(6);
    // Load-use on rs2, then the same with ex_rd=0 (no stall)
    drive(0, 0, 5, 0, 1, 5, 1, 0, 0, 0);
    idle(1);
    drive(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    idle(1);
    // rs1 match but rs1 unused: no stall; rs1 used: stall
    drive(0, 7, 0, 0, 0, 7, 1, 0, 0, 0);
    drive(0, 7, 0, 1, 0, 7, 1, 0, 0, 0);
    // Match without a load: no stall
    drive(0, 7, 0, 1, 0, 7, 0, 0, 0, 0);
    // Redirect beats load-use and I-miss
    drive(0, 0, 5, 0, 1, 5, 1, 1, 1, 0);
    idle(1);
    // I-miss alone, then I-miss under a load-use hold
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 5, 0, 1, 5, 1, 0, 1, 0);
    idle(1);
    // D-memory stall for 3 cycles with a redirect waiting; falling cycle
    // decodes the redirect under RUN rules
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);
    // Timeout: 64 busy cycles, flag stays after busywait falls
    rst_seq(1);
    idle(4);
    for (int i = 0; i < TMO; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);
    // Reset in the middle of a D-memory stall
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Busy for 63 cycles only: no timeout
    for (int i = 0; i < TMO - 6; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    // Counter saturation: 20 stall cycles, 18 redirects
    rst_seq(1);
    idle(4);
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 18; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);
    // Random traffic with small register numbers to hit hazards often
    rst_seq(1);
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 59) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0));
    end
    @(negedge clock);
    #1;
    if (sb.size() != 0) chk("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
